// File: rtl/tube_ctrl_pkg.sv
// Shared constants for the tube display controller: register addresses, display modes, push FSM states.
package tube_ctrl_pkg;

  localparam logic [2:0] ADDR_LOW     = 3'b000;
  localparam logic [2:0] ADDR_HIGH    = 3'b010;
  localparam logic [2:0] ADDR_SPECIAL = 3'b100;
  localparam logic [2:0] ADDR_CTRL    = 3'b110;

  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_BLINK  = 2'b01;
  localparam logic [1:0] MODE_SCROLL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'b00,
    ST_PUSH_LOW     = 2'b01,
    ST_PUSH_HIGH    = 2'b10,
    ST_PUSH_SPECIAL = 2'b11
  } state_t;

  // Rotate a 32-bit word left by whole nibbles (0..7).
  function automatic logic [31:0] rotl_nibbles(input logic [31:0] x, input logic [2:0] pos);
    logic [5:0] sh;
    sh = {1'b0, pos, 2'b00};
    return (x << sh) | (x >> (6'd32 - sh));
  endfunction

endpackage

// File: rtl/tube_step_timer.sv
// Free-running prescaler producing base ticks, plus a 2^rate tick divider that emits one-cycle step pulses.
module tube_step_timer #(
  parameter int PRESCALE = 50000,
  parameter int RATE_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic [RATE_W-1:0] rate,
  output logic              step
);

  localparam int PS_W  = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int CNT_W = (1 << RATE_W) - 1;
  localparam logic [CNT_W-1:0] ALL_ONES = {CNT_W{1'b1}};

  logic [PS_W-1:0]  prescaler;
  logic [CNT_W-1:0] step_cnt;
  logic [CNT_W-1:0] step_max;
  logic             tick;

  assign tick     = (prescaler == PS_W'(PRESCALE - 1));
  assign step_max = ~(ALL_ONES << rate);
  assign step     = enable && tick && (step_cnt == step_max);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      step_cnt  <= '0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      // Counter idles at zero outside the stepping modes so a mode change starts a full period.
      if (clear || !enable)
        step_cnt <= '0;
      else if (tick)
        step_cnt <= (step_cnt == step_max) ? '0 : step_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/tube_display_controller.sv
// Shadows the display registers and pushes them as 3-write passes on CPU change or blink/scroll step.
module tube_display_controller
  import tube_ctrl_pkg::*;
#(
  parameter int PRESCALE = 50000,
  parameter int RATE_W   = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_write_enable,
  input  logic [2:0]  cpu_address,
  input  logic [15:0] cpu_write_data,
  output logic        tube_write_enable,
  output logic [2:0]  tube_address,
  output logic [15:0] tube_write_data,
  output logic        busy
);

  logic [15:0]       shadow_low, shadow_high, shadow_special;
  logic [1:0]        mode;
  logic [RATE_W-1:0] rate;
  logic              phase;
  logic [2:0]        pos;
  logic              dirty;
  state_t            state;
  logic [15:0]       latch_high, latch_special;
  logic [31:0]       rotated;
  logic [15:0]       view_low, view_high, view_special;
  logic              wr_low, wr_high, wr_special, wr_ctrl, wr_any;
  logic              stepping, step;

  assign wr_low     = cpu_write_enable && (cpu_address == ADDR_LOW);
  assign wr_high    = cpu_write_enable && (cpu_address == ADDR_HIGH);
  assign wr_special = cpu_write_enable && (cpu_address == ADDR_SPECIAL);
  assign wr_ctrl    = cpu_write_enable && (cpu_address == ADDR_CTRL);
  assign wr_any     = wr_low || wr_high || wr_special || wr_ctrl;
  assign stepping   = (mode == MODE_BLINK) || (mode == MODE_SCROLL);
  assign busy       = (state != ST_IDLE);

  tube_step_timer #(
    .PRESCALE(PRESCALE),
    .RATE_W  (RATE_W)
  ) u_step_timer (
    .clock (clock),
    .reset (reset),
    .enable(stepping),
    .clear (wr_ctrl),
    .rate  (rate),
    .step  (step)
  );

  always_comb begin
    rotated      = rotl_nibbles({shadow_high, shadow_low}, pos);
    view_low     = shadow_low;
    view_high    = shadow_high;
    view_special = shadow_special;
    case (mode)
      MODE_BLINK:  if (phase) view_special[15:8] = 8'h00;
      MODE_SCROLL: begin
        view_low  = rotated[15:0];
        view_high = rotated[31:16];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shadow_low     <= '0;
      shadow_high    <= '0;
      shadow_special <= '0;
      mode           <= MODE_STATIC;
      rate           <= '0;
    end else begin
      if (wr_low)     shadow_low     <= cpu_write_data;
      if (wr_high)    shadow_high    <= cpu_write_data;
      if (wr_special) shadow_special <= cpu_write_data;
      if (wr_ctrl) begin
        mode <= cpu_write_data[1:0];
        rate <= cpu_write_data[2+RATE_W-1:2];
      end
    end
  end

  // A control write restarts the effect, so it wins over a coincident step.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      phase <= 1'b0;
      pos   <= '0;
    end else if (wr_ctrl) begin
      phase <= 1'b0;
      pos   <= '0;
    end else if (step) begin
      if (mode == MODE_BLINK)  phase <= ~phase;
      if (mode == MODE_SCROLL) pos   <= pos + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      dirty <= 1'b1;
    else if (wr_any || step)
      dirty <= 1'b1;
    else if (state == ST_IDLE)
      dirty <= 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= ST_IDLE;
      tube_write_enable <= 1'b0;
      tube_address      <= ADDR_LOW;
      tube_write_data   <= '0;
      latch_high        <= '0;
      latch_special     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (dirty) begin
          state             <= ST_PUSH_LOW;
          tube_write_enable <= 1'b1;
          tube_address      <= ADDR_LOW;
          tube_write_data   <= view_low;
          latch_high        <= view_high;
          latch_special     <= view_special;
        end
        ST_PUSH_LOW: begin
          state           <= ST_PUSH_HIGH;
          tube_address    <= ADDR_HIGH;
          tube_write_data <= latch_high;
        end
        ST_PUSH_HIGH: begin
          state           <= ST_PUSH_SPECIAL;
          tube_address    <= ADDR_SPECIAL;
          tube_write_data <= latch_special;
        end
        default: begin
          state             <= ST_IDLE;
          tube_write_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tube_display_controller.sv
// Directed bench for tube_display_controller: vector table of CPU writes plus blink/scroll/reset sequences.
module tb_tube_display_controller;
  import tube_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_write_enable = 1'b0;
  logic [2:0]  cpu_address = 3'b000;
  logic [15:0] cpu_write_data = 16'h0000;
  logic        tube_write_enable;
  logic [2:0]  tube_address;
  logic [15:0] tube_write_data;
  logic        busy;

  tube_display_controller #(.PRESCALE(4), .RATE_W(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .cpu_write_enable (cpu_write_enable),
    .cpu_address      (cpu_address),
    .cpu_write_data   (cpu_write_data),
    .tube_write_enable(tube_write_enable),
    .tube_address     (tube_address),
    .tube_write_data  (tube_write_data),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        busy;
    int          cyc;
  } wr_t;
  wr_t q[$];

  always @(negedge clock) begin
    cyc++;
    if (tube_write_enable) q.push_back('{tube_address, tube_write_data, busy, cyc});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    cpu_write_enable = 1'b1;
    cpu_address      = a;
    cpu_write_data   = d;
    tick();
    cpu_write_enable = 1'b0;
  endtask

  task automatic wait_pass(input string nm, input logic [15:0] el, input logic [15:0] eh,
                           input logic [15:0] es, output int first);
    int  n;
    wr_t r[3];
    n = 0;
    first = 0;
    while (q.size() < 3 && n < 40) begin
      tick();
      n++;
    end
    chk({nm, " pass seen"}, 32'(q.size() >= 3), 32'd1);
    if (q.size() < 3) return;
    for (int i = 0; i < 3; i++) r[i] = q.pop_front();
    chk({nm, " addr0"}, 32'(r[0].addr), 32'(ADDR_LOW));
    chk({nm, " addr1"}, 32'(r[1].addr), 32'(ADDR_HIGH));
    chk({nm, " addr2"}, 32'(r[2].addr), 32'(ADDR_SPECIAL));
    chk({nm, " low"}, 32'(r[0].data), 32'(el));
    chk({nm, " high"}, 32'(r[1].data), 32'(eh));
    chk({nm, " special"}, 32'(r[2].data), 32'(es));
    chk({nm, " contiguous"}, 32'(r[2].cyc - r[0].cyc), 32'd2);
    chk({nm, " busy"}, {29'd0, r[0].busy, r[1].busy, r[2].busy}, 32'd7);
    first = r[0].cyc;
  endtask

  task automatic quiet(input string nm);
    q.delete();
    repeat (12) tick();
    chk({nm, " quiet"}, 32'(q.size()), 32'd0);
    chk({nm, " busy idle"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  addr;
    logic [15:0] data;
    logic        pass;
    logic [15:0] lo, hi, sp;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int          f, prev, n;
    logic [15:0] sp;
    logic [31:0] x;

    vecs[0] = '{ADDR_HIGH,    16'h5678, 1'b1, 16'h1234, 16'h5678, 16'h0000};
    vecs[1] = '{ADDR_SPECIAL, 16'h8001, 1'b1, 16'h1234, 16'h5678, 16'h8001};
    vecs[2] = '{ADDR_LOW,     16'hFFFF, 1'b1, 16'hFFFF, 16'h5678, 16'h8001};
    vecs[3] = '{3'b001,       16'hDEAD, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[4] = '{3'b111,       16'hBEEF, 1'b0, 16'h0000, 16'h0000, 16'h0000};
    vecs[5] = '{ADDR_CTRL,    16'hFFE0, 1'b1, 16'hFFFF, 16'h5678, 16'h8001};
    vecs[6] = '{ADDR_CTRL,    16'h0003, 1'b1, 16'hFFFF, 16'h5678, 16'h8001};
    vecs[7] = '{ADDR_CTRL,    16'h0000, 1'b1, 16'hFFFF, 16'h5678, 16'h8001};

    // Reset state and the initialising zero pass.
    repeat (3) tick();
    chk("rst we", 32'(tube_write_enable), 32'd0);
    chk("rst addr", 32'(tube_address), 32'd0);
    chk("rst data", 32'(tube_write_data), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    q.delete();
    reset = 1'b0;
    wait_pass("init", 16'h0000, 16'h0000, 16'h0000, f);
    quiet("init");

    // Latency: write edge, then strobe visible after the next edge.
    cpu_write(ADDR_LOW, 16'h1234);
    chk("lat we0", 32'(tube_write_enable), 32'd0);
    tick();
    chk("lat we1", 32'(tube_write_enable), 32'd1);
    chk("lat a1", 32'(tube_address), 32'(ADDR_LOW));
    chk("lat d1", 32'(tube_write_data), 32'h1234);
    tick();
    chk("lat a2", 32'(tube_address), 32'(ADDR_HIGH));
    chk("lat d2", 32'(tube_write_data), 32'h0000);
    tick();
    chk("lat a3", 32'(tube_address), 32'(ADDR_SPECIAL));
    chk("lat d3", 32'(tube_write_data), 32'h0000);
    tick();
    chk("lat we4", 32'(tube_write_enable), 32'd0);
    quiet("lat");

    for (int i = 0; i < 8; i++) begin
      q.delete();
      cpu_write(vecs[i].addr, vecs[i].data);
      if (vecs[i].pass) wait_pass($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi, vecs[i].sp, f);
      quiet($sformatf("vec%0d", i));
    end

    // Second write lands during PUSH_HIGH of the first pass.
    q.delete();
    cpu_write(ADDR_LOW, 16'hAAAA);
    tick();
    tick();
    chk("b2b in high", 32'(tube_address), 32'(ADDR_HIGH));
    cpu_write(ADDR_HIGH, 16'h5555);
    wait_pass("b2b p1", 16'hAAAA, 16'h5678, 16'h8001, prev);
    wait_pass("b2b p2", 16'hAAAA, 16'h5555, 16'h8001, f);
    chk("b2b gap", 32'(f - prev), 32'd4);
    quiet("b2b");

    // Blink, rate 0: a step every 4 cycles.
    cpu_write(ADDR_SPECIAL, 16'hFF5A);
    wait_pass("blk spec", 16'hAAAA, 16'h5555, 16'hFF5A, f);
    quiet("blk spec");
    cpu_write(ADDR_CTRL, 16'h0001);
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      sp = (k % 2 == 1) ? 16'h005A : 16'hFF5A;
      wait_pass($sformatf("blink%0d", k), 16'hAAAA, 16'h5555, sp, f);
      if (k > 0) chk($sformatf("blink%0d period", k), 32'(f - prev), 32'd4);
      prev = f;
    end
    cpu_write(ADDR_CTRL, 16'h0000);
    repeat (20) tick();
    quiet("blink stop");

    // Blink, rate 1: a step every 8 cycles.
    cpu_write(ADDR_CTRL, 16'h0005);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      sp = (k % 2 == 1) ? 16'h005A : 16'hFF5A;
      wait_pass($sformatf("rate1 %0d", k), 16'hAAAA, 16'h5555, sp, f);
      if (k > 1) chk($sformatf("rate1 %0d period", k), 32'(f - prev), 32'd8);
      prev = f;
    end
    cpu_write(ADDR_CTRL, 16'h0000);
    repeat (30) tick();
    quiet("rate1 stop");

    // Scroll, rate 0: nibble rotation through all 8 positions and back.
    cpu_write(ADDR_LOW, 16'h3210);
    wait_pass("scr low", 16'h3210, 16'h5555, 16'hFF5A, f);
    cpu_write(ADDR_HIGH, 16'h7654);
    wait_pass("scr high", 16'h3210, 16'h7654, 16'hFF5A, f);
    quiet("scr setup");
    cpu_write(ADDR_CTRL, 16'h0002);
    x = 32'h76543210;
    prev = 0;
    for (int k = 0; k < 9; k++) begin
      wait_pass($sformatf("scroll%0d", k), x[15:0], x[31:16], 16'hFF5A, f);
      if (k > 0) chk($sformatf("scroll%0d period", k), 32'(f - prev), 32'd4);
      prev = f;
      x = {x[27:0], x[31:28]};
    end
    cpu_write(ADDR_CTRL, 16'h0000);
    repeat (20) tick();
    quiet("scroll stop");

    // Reset in the middle of a pass.
    cpu_write(ADDR_LOW, 16'hABCD);
    n = 0;
    while (!(tube_write_enable && tube_address == ADDR_HIGH) && n < 10) begin
      tick();
      n++;
    end
    chk("mid reached high", 32'(tube_write_enable && tube_address == ADDR_HIGH), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid we drop", 32'(tube_write_enable), 32'd0);
    chk("mid busy drop", 32'(busy), 32'd0);
    chk("mid data clr", 32'(tube_write_data), 32'd0);
    tick();
    tick();
    q.delete();
    reset = 1'b0;
    wait_pass("mid reinit", 16'h0000, 16'h0000, 16'h0000, f);
    quiet("mid reinit");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
